// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared sizes, FSM state type and helpers for register-file
//               writeback control.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int ADDR_W     = 5;
    localparam int NUM_REGS   = 32;
    localparam int NUM_WB_REQ = 3;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } wb_state_t;

    // Width of an index into n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; search starts at pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]                           req,
    input  logic [regfile_pkg::idx_width(NUM_REQ)-1:0]   pointer,
    output logic [NUM_REQ-1:0]                           grant,
    output logic [regfile_pkg::idx_width(NUM_REQ)-1:0]   grant_idx
);
    import regfile_pkg::*;

    localparam int c_PTR_W = idx_width(NUM_REQ);

    int   w_pos;
    logic w_found;

    // Outer loop walks priority order, so the first hit is the winner.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_pos     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(pointer) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && (i == w_pos) && req[i]) begin
                    w_found   = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = c_PTR_W'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_ctrl
// Description : Zeroes the register file after reset/clear, then arbitrates
//               writeback requesters onto a single registered write port.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl #(
    parameter int NUM_REQ = regfile_pkg::NUM_WB_REQ,
    parameter int XLEN    = regfile_pkg::XLEN,
    parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      clear_req,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_dest,
    output logic [XLEN-1:0]           rf_wdata,
    output logic [1:0]                grant_id,
    output logic                      init_done
);
    import regfile_pkg::*;

    localparam int              c_PTR_W    = idx_width(NUM_REQ);
    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] c_FIRST_IDX = ADDR_W'(1);

    wb_state_t            r_state;
    logic [ADDR_W-1:0]    r_init_cnt;
    logic [c_PTR_W-1:0]   r_rr_ptr;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_PTR_W-1:0]   w_grant_idx;
    logic                 w_arb_en;
    logic                 w_xfer;
    logic [ADDR_W-1:0]    w_sel_dest;
    logic [XLEN-1:0]      w_sel_data;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .pointer   (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // A clear pulse blocks acceptance so no request is taken on the edge
    // that restarts initialisation.
    assign w_arb_en  = (r_state == RUN) && !clear_req;
    assign req_ready = w_arb_en ? w_grant : '0;
    assign w_xfer    = |req_ready;

    always_comb begin
        w_sel_dest = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_dest = req_dest[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT;
            r_init_cnt <= c_FIRST_IDX;
            r_rr_ptr   <= '0;
            rf_we      <= 1'b0;
            rf_dest    <= '0;
            rf_wdata   <= '0;
            grant_id   <= '0;
            init_done  <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (clear_req) begin
                        r_init_cnt <= c_FIRST_IDX;
                        rf_we      <= 1'b0;
                    end else begin
                        rf_we      <= 1'b1;
                        rf_dest    <= r_init_cnt;
                        rf_wdata   <= '0;
                        r_init_cnt <= r_init_cnt + c_FIRST_IDX;
                        if (r_init_cnt == c_LAST_IDX) begin
                            r_state    <= RUN;
                            init_done  <= 1'b1;
                            r_init_cnt <= c_FIRST_IDX;
                        end
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        r_state    <= INIT;
                        r_init_cnt <= c_FIRST_IDX;
                        r_rr_ptr   <= '0;
                        init_done  <= 1'b0;
                        rf_we      <= 1'b0;
                    end else if (w_xfer) begin
                        // Register x0 is hardwired: accept the request, drop the write.
                        rf_we    <= (w_sel_dest != '0);
                        rf_dest  <= w_sel_dest;
                        rf_wdata <= w_sel_data;
                        grant_id <= 2'(w_grant_idx);
                        r_rr_ptr <= (w_grant_idx == c_PTR_W'(NUM_REQ - 1)) ?
                                    '0 : w_grant_idx + c_PTR_W'(1);
                    end else begin
                        rf_we <= 1'b0;
                    end
                end
                default: begin
                    r_state <= INIT;
                    rf_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_ctrl
// Description : Randomized bench for regfile_wb_ctrl with reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_ctrl;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int XL = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_dest;
    logic [N*XL-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            clear_req;
    logic            rf_we;
    logic [AW-1:0]   rf_dest;
    logic [XL-1:0]   rf_wdata;
    logic [1:0]      grant_id;
    logic            init_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit            m_run;
    int            m_cnt;
    int            m_ptr;
    bit            exp_we;
    logic [AW-1:0] exp_dest;
    logic [XL-1:0] exp_wdata;
    int            exp_gid;
    bit            exp_done;

    // Pending requests seen from the requesters' side
    bit            p_valid [N];
    logic [AW-1:0] p_dest  [N];
    logic [XL-1:0] p_data  [N];

    regfile_wb_ctrl #(.NUM_REQ(N), .XLEN(XL), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_dest  (req_dest),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clear_req (clear_req),
        .rf_we     (rf_we),
        .rf_dest   (rf_dest),
        .rf_wdata  (rf_wdata),
        .grant_id  (grant_id),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_cnt = 1; m_ptr = 0;
        exp_we = 0; exp_dest = '0; exp_wdata = '0; exp_gid = 0; exp_done = 0;
    endtask

    function automatic int model_pick(input logic [N-1:0] v, input logic clr);
        if (!m_run || clr) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Drive one cycle of inputs, check ready, advance the model, check outputs.
    task automatic cycle(input logic [N-1:0] v, input logic [N*AW-1:0] d,
                         input logic [N*XL-1:0] dt, input logic clr, output int g);
        logic [N-1:0] er;
        req_valid = v; req_dest = d; req_data = dt; clear_req = clr;
        #1;
        g  = model_pick(v, clr);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(er));
        if (!m_run) begin
            if (clr) begin
                m_cnt = 1; exp_we = 0;
            end else begin
                exp_we = 1; exp_dest = AW'(m_cnt); exp_wdata = '0;
                if (m_cnt == 31) begin m_run = 1; exp_done = 1; end
                m_cnt++;
            end
        end else if (clr) begin
            m_run = 0; m_cnt = 1; m_ptr = 0; exp_done = 0; exp_we = 0;
        end else if (g >= 0) begin
            exp_we    = (d[g*AW +: AW] != 0);
            exp_dest  = d[g*AW +: AW];
            exp_wdata = dt[g*XL +: XL];
            exp_gid   = g;
            m_ptr     = (g + 1) % N;
        end else begin
            exp_we = 0;
        end
        @(posedge clk);
        #1;
        check("rf_we", 64'(rf_we), 64'(exp_we));
        if (exp_we) begin
            check("rf_dest", 64'(rf_dest), 64'(exp_dest));
            check("rf_wdata", 64'(rf_wdata), 64'(exp_wdata));
        end
        check("grant_id", 64'(grant_id), 64'(exp_gid));
        check("init_done", 64'(init_done), 64'(exp_done));
    endtask

    task automatic rand_cycle(input int clr_pct);
        logic [N-1:0]    v;
        logic [N*AW-1:0] d;
        logic [N*XL-1:0] dt;
        int g;
        for (int i = 0; i < N; i++) begin
            if (!p_valid[i] && $urandom_range(0, 3) != 0) begin
                p_valid[i] = 1;
                p_dest[i]  = AW'($urandom_range(0, 31));
                p_data[i]  = $urandom;
            end
            v[i] = p_valid[i];
            d[i*AW +: AW] = p_dest[i];
            dt[i*XL +: XL] = p_data[i];
        end
        cycle(v, d, dt, ($urandom_range(0, 99) < clr_pct), g);
        if (g >= 0) p_valid[g] = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_we"},    64'(rf_we),     64'd0);
        check({tag, "_dest"},  64'(rf_dest),   64'd0);
        check({tag, "_wdata"}, 64'(rf_wdata),  64'd0);
        check({tag, "_gid"},   64'(grant_id),  64'd0);
        check({tag, "_done"},  64'(init_done), 64'd0);
    endtask

    initial begin
        int g;
        logic [N*XL-1:0] dt;
        rst_n = 0; req_valid = '0; req_dest = '0; req_data = '0; clear_req = 0;
        for (int i = 0; i < N; i++) begin p_valid[i] = 0; p_dest[i] = '0; p_data[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        model_reset();
        rst_n = 1;

        // Initialisation sweep with requesters already waiting
        repeat (31) rand_cycle(0);
        for (int i = 0; i < N; i++) p_valid[i] = 0;

        // All three requesters continuously valid
        dt = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        repeat (6) cycle(3'b111, {5'd3, 5'd2, 5'd1}, dt, 1'b0, g);

        cycle(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 1'b0, g);
        cycle(3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h12345678}, 1'b0, g);
        cycle(3'b011, {5'd0, 5'd9, 5'd4}, {32'h0, 32'h99, 32'h44}, 1'b0, g);

        // Clear while requester 2 waits; it wins the first RUN cycle afterwards
        dt = {32'h22222222, 32'h0, 32'h0};
        cycle(3'b100, {5'd7, 5'd0, 5'd0}, dt, 1'b1, g);
        repeat (31) cycle(3'b100, {5'd7, 5'd0, 5'd0}, dt, 1'b0, g);
        cycle(3'b100, {5'd7, 5'd0, 5'd0}, dt, 1'b0, g);
        check("clr_first_grant", 64'(g), 64'd2);

        repeat (500) rand_cycle(3);

        // Reset in the middle of initialisation
        cycle('0, '0, '0, 1'b1, g);
        repeat (12) cycle('0, '0, '0, 1'b0, g);
        #2 rst_n = 0;
        #1;
        check_zero_outputs("midinit_rst");
        model_reset();
        for (int i = 0; i < N; i++) p_valid[i] = 0;
        @(posedge clk);
        #1 rst_n = 1;
        repeat (40) rand_cycle(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 Parameter NUM_REQ, default 3, number of writeback requesters (ALU, LSU, CSR).
REQ-002 Parameter XLEN, default 32, write data width.
REQ-003 Parameter ADDR_W, default 5, register index width.
REQ-004 One clock; reset is asynchronous and active-low. Ports: clk, input, 1, sole clock, all state on posedge; rst_n, input, 1, asynchronous active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester write request valid.
REQ-006 req_dest  input  NUM_REQ x ADDR_W  per-requester destination register index.
REQ-007 req_data  input  NUM_REQ x XLEN  per-requester write data.
REQ-008 req_ready  output  NUM_REQ  one-hot grant; transfer on valid&ready.
REQ-009 clear_req  input  1  single-cycle pulse requesting re-zeroing of the register file.
REQ-010 rf_we  output  1  register file write enable, registered.
REQ-011 rf_dest  output  ADDR_W  register file write index, registered.
REQ-012 rf_wdata  output  XLEN  register file write data, registered.
REQ-013 grant_id  output  2  index of last accepted requester, registered.
REQ-014 init_done  output  1  high while in RUN; register file contents defined.

Function
REQ-015 FSM states INIT and RUN; state after reset is INIT with init counter = 1.
REQ-016 INIT: each posedge registers rf_we=1, rf_dest=counter, rf_wdata=0, then increments counter; indices 1..31 written in 31 consecutive cycles.
REQ-017 INIT: edge that registers dest 31 also moves state to RUN and sets init_done=1; rf_we for dest 31 and init_done rise in the same cycle.
REQ-018 INIT: req_ready = 0 for all requesters.
REQ-019 RUN: req_ready combinational, round-robin among asserted req_valid starting at rr pointer; at most one bit set; all zero when no req_valid.
REQ-020 rr pointer reset to 0, also reset to 0 on every INIT entry; after a transfer by requester i it becomes (i+1) mod NUM_REQ.
REQ-021 Transfer by i registers rf_we=1, rf_dest=req_dest[i], rf_wdata=req_data[i], grant_id=i on that edge; latency exactly 1 cycle; throughput one write per cycle.
REQ-022 Transfer with req_dest[i]==0: accepted (ready=1, pointer advances, grant_id updated) but rf_we=0 next cycle.
REQ-023 RUN cycle with no transfer: rf_we=0 next cycle; rf_dest, rf_wdata, grant_id hold.
REQ-024 Requesters hold valid, dest, data stable until ready; block does not buffer unaccepted requests.
REQ-025 clear_req in RUN: req_ready forced 0 in that cycle (no transfer); on that edge state->INIT, counter=1, init_done=0, rf_we=0; next edge begins dest-1 write.
REQ-026 clear_req in INIT: counter restarts at 1 on that edge; rf_we=0 that edge.
REQ-027 Write registered before clear_req edge completes normally; no write is lost or duplicated.

Reset
REQ-028 rst_n low asynchronously forces: state INIT, counter 1, rr pointer 0, rf_we 0, rf_dest 0, rf_wdata 0, grant_id 0, init_done 0; req_ready 0 while rst_n low.
REQ-029 Reset asserted mid-INIT or mid-RUN abandons progress; full 31-cycle INIT repeats after release.

Structure
REQ-030 Package regfile_pkg holds XLEN, ADDR_W, NUM_REGS=32, NUM_WB_REQ=3 and the wb_state_t enum {INIT, RUN}.
REQ-031 One sub-module rr_arbiter (NUM_REQ param; inputs req, pointer; output one-hot grant, grant index) instantiated once.

Verification
REQ-032 Release reset -> rf_we=1 with rf_dest 1..31, rf_wdata 0, 31 consecutive cycles; init_done=1 in cycle of dest 31; req_ready 0 throughout.
REQ-033 RUN, all three req_valid held high with distinct dests -> grants 0,1,2,0,1,2; rf_we high every cycle, 1-cycle lag.
REQ-034 RUN, only requester 1 valid, dest 5, data 0xDEADBEEF -> req_ready=3'b010 same cycle; next cycle rf_we=1, rf_dest=5, rf_wdata=0xDEADBEEF, grant_id=1.
REQ-035 Requester 0 valid, dest 0, data 0x12345678 -> ready=3'b001, next cycle rf_we=0, grant_id=0; next grant starts from requester 1.
REQ-036 clear_req pulse with requester 2 valid -> req_ready=0 that cycle, 31 zero writes, init_done re-rises, then requester 2 granted first cycle of RUN.
REQ-037 rst_n low during INIT at dest 12 -> outputs zero immediately; after release writes restart at dest 1.
